// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         PS2_EVT_W      = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO with registered count; push while full succeeds only with a same-cycle pop.
module ps2_event_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Zeroed when empty so the head reads 0 out of reset.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 frame receiver with E0/F0 prefix folding and an event FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames failing odd parity.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       H2L_Sig,
  input  logic       PS2_Data_Pin_In,
  output logic [7:0] Key_Code,
  output logic       Key_Ext,
  output logic       Key_Break,
  output logic       Key_Valid,
  input  logic       Key_Ready,
  output logic       Frame_Err,
  output logic       Overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tmo_cnt;
  logic          ext, brk;
  logic          par_ok, stop_good, is_prefix, push, pop;
  logic          fifo_full, fifo_empty;
  ps2_evt_t      push_evt, head_evt;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  assign par_ok = ^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  assign stop_good = (state == STOP) && H2L_Sig && PS2_Data_Pin_In && par_ok;
  assign is_prefix = (shreg == PS2_PREFIX_EXT) || (shreg == PS2_PREFIX_BRK);
  // Push on the stop-bit edge itself so Key_Valid rises one cycle after it.
  assign push      = stop_good && !is_prefix;
  assign push_evt  = '{ext: ext, brk: brk, code: shreg};
  assign pop       = Key_Valid & Key_Ready;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tmo_cnt   <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      Frame_Err <= 1'b0;
      Overflow  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      Frame_Err <= 1'b0;
      Overflow  <= push && fifo_full && !pop;
      if (H2L_Sig) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (!PS2_Data_Pin_In) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              Frame_Err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end
          end
          DATA: begin
            shreg   <= {PS2_Data_Pin_In, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= PS2_Data_Pin_In;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (stop_good) begin
              if (shreg == PS2_PREFIX_EXT)      ext <= 1'b1;
              else if (shreg == PS2_PREFIX_BRK) brk <= 1'b1;
              else begin
                ext <= 1'b0;
                brk <= 1'b0;
              end
            end else begin
              Frame_Err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= IDLE;
          tmo_cnt   <= '0;
          Frame_Err <= 1'b1;
          ext       <= 1'b0;
          brk       <= 1'b0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

  ps2_event_fifo #(
    .W     (PS2_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .push  (push),
    .wdata (push_evt),
    .pop   (pop),
    .rdata (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Key_Valid = ~fifo_empty;
  assign Key_Code  = head_evt.code;
  assign Key_Ext   = head_evt.ext;
  assign Key_Break = head_evt.brk;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: framing, prefixes, parity, timeout, overflow, mid-frame reset.
module tb_ps2_scan_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic       CLK = 1'b0, RSTn = 1'b0, H2L_Sig = 1'b0, PS2_Data_Pin_In = 1'b1, Key_Ready = 1'b0;
  logic [7:0] Key_Code;
  logic       Key_Ext, Key_Break, Key_Valid, Frame_Err, Overflow;

  int   tests = 0, fails = 0, ferr_cnt = 0, ovf_cnt = 0, f0, o0;
  logic vld_pre, vld_post, ovf_post, ferr_post;

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RSTn(RSTn), .H2L_Sig(H2L_Sig), .PS2_Data_Pin_In(PS2_Data_Pin_In),
    .Key_Code(Key_Code), .Key_Ext(Key_Ext), .Key_Break(Key_Break), .Key_Valid(Key_Valid),
    .Key_Ready(Key_Ready), .Frame_Err(Frame_Err), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  // Each cycle high counts as one pulse, so a stretched pulse shows up as an extra count.
  always @(posedge CLK) begin
    if (Frame_Err === 1'b1) ferr_cnt++;
    if (Overflow === 1'b1)  ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    PS2_Data_Pin_In = b;
    H2L_Sig = 1'b1;
    @(posedge CLK);
    #1;
    H2L_Sig = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    vld_pre = Key_Valid;
    send_bit(stp);
    vld_post  = Key_Valid;
    ovf_post  = Overflow;
    ferr_post = Frame_Err;
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  task automatic pop_one;
    @(negedge CLK);
    Key_Ready = 1'b1;
    @(posedge CLK);
    #1;
    Key_Ready = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [7:0] code, input logic e, input logic br);
    check({tag, "_valid"}, Key_Valid, 1);
    check({tag, "_code"},  Key_Code,  code);
    check({tag, "_ext"},   Key_Ext,   e);
    check({tag, "_brk"},   Key_Break, br);
  endtask

  task automatic settle;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", Key_Valid, 0);
    check("rst_code",  Key_Code,  8'h00);
    check("rst_ext",   Key_Ext,   0);
    check("rst_brk",   Key_Break, 0);
    check("rst_ferr",  Frame_Err, 0);
    check("rst_ovf",   Overflow,  0);
    @(negedge CLK);
    RSTn = 1'b1;

    // Plain make code and its latency
    send_key(8'h1C);
    check("lat_pre",  vld_pre,  0);
    check("lat_post", vld_post, 1);
    expect_head("k1c", 8'h1C, 1'b0, 1'b0);
    pop_one;
    check("k1c_drained", Key_Valid, 0);

    // Extended break: prefixes fold into one event
    send_key(8'hE0);
    check("e0_noevt", Key_Valid, 0);
    send_key(8'hF0);
    check("f0_noevt", Key_Valid, 0);
    send_key(8'h75);
    expect_head("k75", 8'h75, 1'b1, 1'b1);
    pop_one;
    check("k75_single", Key_Valid, 0);

    // Bad parity (0x1C carries odd parity with parity bit 0)
    f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("par_ferr_pulse", ferr_post, 1);
    check("par_noevt",      Key_Valid, 0);
    settle;
    check("par_ferr_cnt",   ferr_cnt - f0, 1);
`else
    expect_head("par_ign", 8'h1C, 1'b0, 1'b0);
    settle;
    check("par_ferr_cnt", ferr_cnt - f0, 0);
    pop_one;
`endif

    // Start bit of 1 is rejected
    f0 = ferr_cnt;
    send_bit(1'b1);
    settle;
    check("start_ferr_cnt", ferr_cnt - f0, 1);

    // Stop-bit error clears a pending E0
    send_key(8'hE0);
    f0 = ferr_cnt;
    send_frame(8'h11, ~^8'h11, 1'b0);
    check("stop_ferr_pulse", ferr_post, 1);
    settle;
    check("stop_ferr_cnt", ferr_cnt - f0, 1);
    send_key(8'h11);
    expect_head("k11", 8'h11, 1'b0, 1'b0);
    pop_one;

    // Timeout after 4 data bits, then recovery
    f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TMO + 5) @(posedge CLK);
    #1;
    check("tmo_ferr_cnt", ferr_cnt - f0, 1);
    check("tmo_noevt",    Key_Valid, 0);
    send_key(8'h29);
    expect_head("k29", 8'h29, 1'b0, 1'b0);
    pop_one;
    check("k29_drained", Key_Valid, 0);

    // Overflow: DEPTH+1 codes with no consumer
    o0 = ovf_cnt;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      send_key(8'(k));
      if (k == DEPTH) check("ovf_none_yet", ovf_cnt - o0, 0);
    end
    check("ovf_pulse", ovf_post, 1);
    settle;
    check("ovf_cnt", ovf_cnt - o0, 1);
    for (int k = 1; k <= DEPTH; k++) begin
      expect_head($sformatf("drain%0d", k), 8'(k), 1'b0, 1'b0);
      pop_one;
    end
    check("drain_empty", Key_Valid, 0);

    // Reset mid-frame discards queue, partial frame and the F0 flag
    send_key(8'h33);
    send_key(8'hF0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check("mid_rst_valid", Key_Valid, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    send_key(8'h16);
    expect_head("k16", 8'h16, 1'b0, 1'b0);
    pop_one;
    check("k16_only", Key_Valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Parametrised PS/2 keyboard receiver that turns the device data line, sampled on host-detected clock falling edges, into complete key events. It validates each 11-bit frame, folds the 0xE0 (extended) and 0xF0 (break) prefixes into flags on the following code byte, and queues finished events in a small FIFO with a valid/ready handshake. It sits between the PS/2 clock edge detector and any scan-code consumer (display, command decoder), replacing the single-byte, unbuffered decoder.

## Interface
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..64.
- TIMEOUT_CYCLES, 50000: CLK cycles without H2L_Sig mid-frame before the frame is aborted; must be ≥ 2.
- CLK  in  1  system clock.
- RSTn  in  1  reset; asynchronous, active-low.
- H2L_Sig  in  1  one-cycle pulse per PS/2 clock falling edge.
- PS2_Data_Pin_In  in  1  synchronised PS/2 data line.
- Key_Code  out  8  code byte of the head event.
- Key_Ext  out  1  head event was preceded by 0xE0.
- Key_Break  out  1  head event was preceded by 0xF0 (key release).
- Key_Valid  out  1  FIFO non-empty; head fields valid.
- Key_Ready  in  1  consumer accepts the head event when Key_Valid && Key_Ready.
- Frame_Err  out  1  one-cycle pulse on a rejected frame (start, stop, parity or timeout).
- Overflow  out  1  one-cycle pulse when a finished event is dropped because the FIFO is full.

## Operation
- Frame FSM: IDLE → DATA → PARITY → STOP → IDLE. Each transition and each sample occurs only in cycles where H2L_Sig = 1.
- IDLE: sample the start bit. A value of 0 selects DATA with bit count 0. A value of 1 raises Frame_Err and the FSM stays in IDLE.
- DATA: shift the samples LSB-first into the byte. After 8 bits the FSM selects PARITY.
- PARITY: capture the parity bit and select STOP.
- STOP: a sample of 1 with a parity result of OK makes the frame good. Any other result raises Frame_Err. In both cases the FSM returns to IDLE.
- Prefix tracker on each good byte:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte forms the event {ext, brk, byte} and clears both flags.
  - Prefixes never produce events. Repeated prefixes are idempotent.
- Frame_Err (any cause) clears ext and brk.
- Timeout: a counter runs whenever the FSM is not in IDLE and resets on every H2L_Sig. On reaching TIMEOUT_CYCLES the FSM returns to IDLE, Frame_Err pulses and the prefix flags clear.
- FIFO behaviour:
  - An event is pushed in the cycle after its stop-bit sample.
  - If the FIFO is full and no pop happens in that cycle, the event is dropped and Overflow pulses.
  - A simultaneous push and pop while full succeeds; the count is unchanged.
  - A pop while empty is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Head fields are show-ahead. The fields are don't-care when Key_Valid = 0.

## Timing
- Reset (asynchronous assert, synchronous release): FSM in IDLE, counters 0, flags 0, FIFO empty. All outputs are 0: Key_Code = 0x00, Key_Ext = Key_Break = Key_Valid = Frame_Err = Overflow = 0.
- A reset mid-frame discards the partial frame, the prefix flags and all queued events.
- Latency: the stop-bit H2L_Sig at cycle N gives Key_Valid = 1 at cycle N+1 when the FIFO was empty.
- Frame_Err and Overflow assert at N+1 for a stop-bit-cycle error, or at the timeout cycle +1. Each lasts exactly one cycle.
- A pop at edge M updates the head at M+1, or deasserts Key_Valid at M+1 if the last entry was popped.
- Key_Ready has no effect on frame reception. Back-to-back frames never stall.

## Configuration
- PS2_PARITY_CHECK_EN defined: odd parity over the 8 data bits plus the parity bit is required. A mismatch rejects the frame and pulses Frame_Err.
- PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored. Only the start bit, the stop bit and the timeout can reject a frame.

## Structure
- Package ps2_pkg holds:
  - the frame FSM state enum (IDLE, DATA, PARITY, STOP);
  - the constants PS2_PREFIX_EXT = 8'hE0 and PS2_PREFIX_BRK = 8'hF0;
  - the event width constant (10 bits: ext, brk, code).
- Sub-module ps2_event_fifo is a parametrised synchronous FIFO with registered count, wrap pointers, push/pop, full and empty. It instantiates once with width 10 and depth FIFO_DEPTH.

## Test plan
- Frame 0x1C with odd parity 0 and stop 1 → one event: Key_Code = 0x1C, Ext = 0, Break = 0, Key_Valid at the stop cycle +1.
- Byte sequence E0 F0 75 → exactly one event: Key_Code = 0x75, Ext = 1, Break = 1. Neither prefix queues an event.
- Frame 0x1C with parity 1 → with PS2_PARITY_CHECK_EN: Frame_Err pulse, no event. Without it: event 0x1C.
- Frame that stops after 4 data bits; wait TIMEOUT_CYCLES → Frame_Err pulse, FSM in IDLE. A following 0x29 frame decodes correctly.
- Key_Ready = 0 while FIFO_DEPTH + 1 codes (0x01..0x05 at depth 4) arrive → the fifth code is dropped with an Overflow pulse. Then Key_Ready = 1 drains 0x01..0x04 in order and Key_Valid drops after the fourth pop.
- Assert RSTn = 0 after F0 plus 5 bits of the next frame, release it, then send 0x16 → event 0x16 with Break = 0 and the FIFO previously empty.
